stage_memory: RTL and testbench
===============================

Name: stage_memory

Overview:
- Memory-access pipeline stage, between execute and write-back.
- Takes the execute-stage record (t_stage) and services RDL (load) and STR (store) through a single-outstanding request/ready handshake to the data cache.
- Registers the resulting t_stage record for write-back and stalls upstream while a memory access is pending.
- Non-memory operations pass through with one cycle of latency.

Parameters:
- ADDR_W, 32, width of mem_addr; low ADDR_W bits of the address are used.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stage_ex  in  t_stage  record from execute stage: operation, rw, result (ALU result / address), value (store data)
- stall  out  1  high = upstream must hold stage_ex unchanged
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  V32  store data
- mem_ready  in  1  request completed this cycle; mem_rdata valid if load
- mem_rdata  in  V32  load data
- stage_mem  out  t_stage  registered record to write-back

Behaviour:
- Reset (reset low, asynchronous):
  - stage_mem = {operation NOP, rw 0, result 0, value 0}
  - state IDLE, halted 0
  - mem_req, mem_we, mem_addr, mem_wdata, stall all 0
- States:
  - IDLE: accepting input
  - REQ: memory access outstanding
- IDLE, halted=0, each cycle:
  - operation RDL or STR:
    - latch request regs: op, rw, addr = stage_ex.result[ADDR_W-1:0], wdata = stage_ex.value, we = (op==STR)
    - stage_mem <= NOP bubble
    - go to REQ
  - operation FINISHED: stage_mem <= stage_ex; halted <= 1
  - any other operation: stage_mem <= stage_ex (1-cycle latency)
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_wdata are driven from request regs and are stable until mem_ready is sampled high.
  - mem_ready=0: stage_mem <= NOP; remain in REQ.
  - mem_ready=1:
    - stage_mem <= {op, rw, result = (RDL ? mem_rdata : addr zero-extended), value = wdata}
    - go to IDLE
    - mem_req is deasserted the following cycle.
- stall:
  - Combinational: stall = (state==REQ).
  - Also held at 1 while halted.
  - A memory op costs one upstream bubble after mem_ready. Example: accept at T, mem_req from T+1, ready at R, stage_mem valid at R+1, next instruction accepted at R+1.
- Halted:
  - Input is ignored; stage_mem holds FINISHED indefinitely.
  - Only reset clears halted.
- mem_ready while in IDLE is ignored. No spurious responses are expected; SVA flags them.
- Reset asserted mid-REQ: mem_req drops asynchronously and the request is abandoned. The cache side must tolerate a withdrawn request.
- Width: the address is truncated to ADDR_W; the STR result is zero-extended back to 32 bits.

Optional Feature:
- STAGE_MEM_STATS_EN defined:
  - adds outputs stall_cycles (V32) and mem_ops (V32)
  - stall_cycles increments every cycle state==REQ
  - mem_ops increments on each mem_ready in REQ
  - both saturate at 32'hFFFF_FFFF and reset to 0
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/common header gets:
  - the t_stage field `value` (V32)
  - operation codes NOP, RDL, STR, FINISHED alongside ALO/AHI/ADD/SUB/AND
  - a state enum t_mem_state {IDLE, REQ}
- No sub-module is needed. The optional counters may be a small saturating-counter module, sat_counter32, instantiated twice.

Test Plan:
- ADD with result=32'h0000_0005, rw=3 → stage_mem equals the input one cycle later; stall stays 0; mem_req never rises.
- RDL with result=32'h100, mem_ready after 3 REQ cycles with rdata=32'hDEAD_BEEF:
  - mem_req high 3 cycles with addr 0x100, we=0
  - stage_mem = RDL, result 0xDEADBEEF, one cycle after ready
  - stall high for exactly 3 cycles
- STR with result=0x40, value=0x1234, mem_ready in the first REQ cycle:
  - one cycle with mem_req=1, we=1, wdata=0x1234
  - stage_mem.result=0x40
  - the following SUB is accepted the cycle after
- Back-to-back RDL, RDL, ADD with variable ready latency (0–4 cycles) → in-order output, correct data, NOP bubbles only between ops, upstream held stable during stall.
- FINISHED followed by ADD → stage_mem stays FINISHED forever, stall=1, ADD never appears.
- Reset pulsed low mid-REQ → mem_req=0 and stage_mem=NOP immediately; the next RDL after release behaves normally. With STAGE_MEM_STATS_EN, counters read 0 after reset and 3 and 1 after the second scenario.

Source files
------------

// File: rtl/stage_memory_pkg.sv
// Shared types for the memory-access pipeline stage: operation codes, the
// stage record passed between pipeline stages, and the memory FSM states.
package stage_memory_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RW_W   = 5;

  typedef logic [DATA_W-1:0] V32;

  typedef enum logic [3:0] {
    NOP      = 4'd0,
    ALO      = 4'd1,
    AHI      = 4'd2,
    ADD      = 4'd3,
    SUB      = 4'd4,
    AND      = 4'd5,
    RDL      = 4'd6,
    STR      = 4'd7,
    FINISHED = 4'd8
  } t_operation;

  typedef struct packed {
    t_operation      operation;
    logic [RW_W-1:0] rw;
    V32              result;
    V32              value;
  } t_stage;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } t_mem_state;

  localparam t_stage STAGE_NOP = '{operation: NOP, rw: '0, result: '0, value: '0};

  function automatic logic is_mem_op(input t_operation op);
    return (op == RDL) || (op == STR);
  endfunction

endpackage

// File: rtl/stage_memory.sv
// Memory-access stage: services RDL/STR through a single-outstanding cache
// handshake, passes other ops through. Define STAGE_MEM_STATS_EN for counters.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  t_stage            stage_ex,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output V32                mem_wdata,
  input  logic              mem_ready,
  input  V32                mem_rdata,
  output t_stage            stage_mem
`ifdef STAGE_MEM_STATS_EN
  ,
  output V32                stall_cycles,
  output V32                mem_ops
`endif
);

  t_mem_state        state, state_n;
  logic              halted, halted_n;
  t_stage            stage_mem_n;
  t_operation        req_op, req_op_n;
  logic [RW_W-1:0]   req_rw, req_rw_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n;
  V32                req_wdata, req_wdata_n;
  logic              req_we, req_we_n;

  // State and request registers; reset withdraws any outstanding request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      halted    <= 1'b0;
      stage_mem <= STAGE_NOP;
      req_op    <= NOP;
      req_rw    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
    end else begin
      state     <= state_n;
      halted    <= halted_n;
      stage_mem <= stage_mem_n;
      req_op    <= req_op_n;
      req_rw    <= req_rw_n;
      req_addr  <= req_addr_n;
      req_wdata <= req_wdata_n;
      req_we    <= req_we_n;
    end
  end

  // Next-state and next-record logic
  always_comb begin
    state_n     = state;
    halted_n    = halted;
    stage_mem_n = stage_mem;
    req_op_n    = req_op;
    req_rw_n    = req_rw;
    req_addr_n  = req_addr;
    req_wdata_n = req_wdata;
    req_we_n    = req_we;

    unique case (state)
      IDLE: begin
        if (!halted) begin
          if (is_mem_op(stage_ex.operation)) begin
            req_op_n    = stage_ex.operation;
            req_rw_n    = stage_ex.rw;
            req_addr_n  = stage_ex.result[ADDR_W-1:0];
            req_wdata_n = stage_ex.value;
            req_we_n    = (stage_ex.operation == STR);
            stage_mem_n = STAGE_NOP;
            state_n     = REQ;
          end else begin
            stage_mem_n = stage_ex;
            if (stage_ex.operation == FINISHED) halted_n = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          stage_mem_n.operation = req_op;
          stage_mem_n.rw        = req_rw;
          stage_mem_n.result    = (req_op == RDL) ? mem_rdata : DATA_W'(req_addr);
          stage_mem_n.value     = req_wdata;
          state_n               = IDLE;
        end else begin
          stage_mem_n = STAGE_NOP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = req_we;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign stall     = (state == REQ) || halted;

`ifdef STAGE_MEM_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      mem_ops      <= '0;
    end else begin
      if ((state == REQ) && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if ((state == REQ) && mem_ready && (mem_ops != '1)) mem_ops <= mem_ops + 32'd1;
    end
  end
`endif

  // The cache must only respond to an outstanding request
  a_no_spurious_ready: assert property (@(posedge clock) disable iff (!reset)
    mem_ready |-> (state == REQ));

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: pass-through vector table plus hand-written
// load/store, back-to-back, halt and mid-request reset sequences.
module tb_stage_memory;
  import stage_memory_pkg::*;

  logic        clock;
  logic        reset;
  t_stage      stage_ex;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  V32          mem_wdata;
  logic        mem_ready;
  V32          mem_rdata;
  t_stage      stage_mem;
`ifdef STAGE_MEM_STATS_EN
  V32          stall_cycles;
  V32          mem_ops;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  stage_memory #(.ADDR_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .stage_ex  (stage_ex),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stage_mem (stage_mem)
`ifdef STAGE_MEM_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .mem_ops      (mem_ops)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input t_stage act, input t_stage exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got op=%0d rw=%0d res=%h val=%h expected op=%0d rw=%0d res=%h val=%h",
               name, act.operation, act.rw, act.result, act.value,
               exp.operation, exp.rw, exp.result, exp.value);
    end
  endtask

  // One memory op: accept, wait_cycles REQ cycles without ready, then a ready cycle
  task automatic mem_op(input string tag, input t_operation op, input logic [31:0] res,
                        input logic [31:0] val, input int wait_cycles, input logic [31:0] rdata);
    t_stage exp;
    stage_ex  = '{operation: op, rw: 5'd3, result: res, value: val};
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i <= wait_cycles; i++) begin
      chk_b({tag, " mem_req"}, mem_req, 1'b1);
      chk_b({tag, " stall"}, stall, 1'b1);
      chk_w({tag, " mem_addr"}, mem_addr, res);
      chk_b({tag, " mem_we"}, mem_we, op == STR);
      if (op == STR) chk_w({tag, " mem_wdata"}, mem_wdata, val);
      chk_s({tag, " bubble"}, stage_mem, STAGE_NOP);
      if (i == wait_cycles) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      cyc();
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    exp = '{operation: op, rw: 5'd3, result: (op == RDL) ? rdata : res, value: val};
    chk_s({tag, " result"}, stage_mem, exp);
    chk_b({tag, " stall after"}, stall, 1'b0);
    chk_b({tag, " mem_req after"}, mem_req, 1'b0);
  endtask

  typedef struct {
    t_stage in;
    t_stage exp;
  } pass_vec_t;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    logic [31:0] rdata;
  } rd_vec_t;

  pass_vec_t pv[6];
  rd_vec_t   rv[5];
  t_stage    fin_rec;
  t_stage    sub_rec;

  initial begin
    pv[0] = '{in: '{operation: ADD, rw: 5'd3, result: 32'h0000_0005, value: 32'h0},
              exp: '{operation: ADD, rw: 5'd3, result: 32'h0000_0005, value: 32'h0}};
    pv[1] = '{in: '{operation: SUB, rw: 5'd7, result: 32'hFFFF_FFFF, value: 32'h1},
              exp: '{operation: SUB, rw: 5'd7, result: 32'hFFFF_FFFF, value: 32'h1}};
    pv[2] = '{in: '{operation: AND, rw: 5'd31, result: 32'hA5A5_0000, value: 32'h55},
              exp: '{operation: AND, rw: 5'd31, result: 32'hA5A5_0000, value: 32'h55}};
    pv[3] = '{in: '{operation: ALO, rw: 5'd1, result: 32'h0000_BEEF, value: 32'h0},
              exp: '{operation: ALO, rw: 5'd1, result: 32'h0000_BEEF, value: 32'h0}};
    pv[4] = '{in: '{operation: AHI, rw: 5'd2, result: 32'hCAFE_0000, value: 32'h9},
              exp: '{operation: AHI, rw: 5'd2, result: 32'hCAFE_0000, value: 32'h9}};
    pv[5] = '{in: '{operation: NOP, rw: 5'd0, result: 32'h0, value: 32'h0},
              exp: '{operation: NOP, rw: 5'd0, result: 32'h0, value: 32'h0}};

    rv[0] = '{addr: 32'h0000_0200, lat: 0, rdata: 32'h1111_2222};
    rv[1] = '{addr: 32'h0000_0204, lat: 4, rdata: 32'h3333_4444};
    rv[2] = '{addr: 32'h0000_0208, lat: 1, rdata: 32'h5555_6666};
    rv[3] = '{addr: 32'h0000_020C, lat: 3, rdata: 32'h7777_8888};
    rv[4] = '{addr: 32'h0000_0210, lat: 2, rdata: 32'h9999_AAAA};

    reset     = 1'b0;
    stage_ex  = STAGE_NOP;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    #3;
    chk_s("reset stage_mem", stage_mem, STAGE_NOP);
    chk_b("reset stall", stall, 1'b0);
    chk_b("reset mem_req", mem_req, 1'b0);
    chk_b("reset mem_we", mem_we, 1'b0);
    chk_w("reset mem_addr", mem_addr, 32'h0);
    chk_w("reset mem_wdata", mem_wdata, 32'h0);
`ifdef STAGE_MEM_STATS_EN
    chk_w("reset stall_cycles", stall_cycles, 32'h0);
    chk_w("reset mem_ops", mem_ops, 32'h0);
`endif
    #9 reset = 1'b1;
    cyc();

    // Pass-through table: one cycle latency, no stall, no request
    for (int i = 0; i < 6; i++) begin
      stage_ex = pv[i].in;
      cyc();
      chk_s($sformatf("pass[%0d] stage_mem", i), stage_mem, pv[i].exp);
      chk_b($sformatf("pass[%0d] stall", i), stall, 1'b0);
      chk_b($sformatf("pass[%0d] mem_req", i), mem_req, 1'b0);
    end

    // Load with three REQ cycles
    mem_op("rdl100", RDL, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);

    // Store ready in first REQ cycle, then SUB accepted next cycle
    mem_op("str40", STR, 32'h0000_0040, 32'h0000_1234, 0, 32'hFFFF_0000);
    sub_rec  = '{operation: SUB, rw: 5'd4, result: 32'h0000_0009, value: 32'h0};
    stage_ex = sub_rec;
    cyc();
    chk_s("sub after str", stage_mem, sub_rec);

    // Back-to-back loads with varied latency, then ADD
    for (int i = 0; i < 5; i++)
      mem_op($sformatf("b2b[%0d]", i), RDL, rv[i].addr, 32'h0, rv[i].lat, rv[i].rdata);
    stage_ex = pv[0].in;
    cyc();
    chk_s("add after b2b", stage_mem, pv[0].exp);

    // Halt: FINISHED sticks, later ADD never appears
    fin_rec  = '{operation: FINISHED, rw: 5'd0, result: 32'h0000_0077, value: 32'h0};
    stage_ex = fin_rec;
    cyc();
    chk_s("finished stage_mem", stage_mem, fin_rec);
    chk_b("finished stall", stall, 1'b1);
    stage_ex = pv[0].in;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_s($sformatf("halted[%0d] stage_mem", i), stage_mem, fin_rec);
      chk_b($sformatf("halted[%0d] stall", i), stall, 1'b1);
      chk_b($sformatf("halted[%0d] mem_req", i), mem_req, 1'b0);
    end

    // Reset clears halt
    reset    = 1'b0;
    stage_ex = STAGE_NOP;
    #2;
    chk_b("unhalt stall", stall, 1'b0);
    chk_s("unhalt stage_mem", stage_mem, STAGE_NOP);
    reset = 1'b1;
    cyc();

    // Reset asserted while a load is outstanding
    stage_ex = '{operation: RDL, rw: 5'd3, result: 32'h0000_0300, value: 32'h0};
    cyc();
    chk_b("midreq mem_req before", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_b("midreq mem_req dropped", mem_req, 1'b0);
    chk_s("midreq stage_mem", stage_mem, STAGE_NOP);
    chk_b("midreq stall", stall, 1'b0);
`ifdef STAGE_MEM_STATS_EN
    chk_w("midreq stall_cycles", stall_cycles, 32'h0);
    chk_w("midreq mem_ops", mem_ops, 32'h0);
`endif
    stage_ex = STAGE_NOP;
    #2 reset = 1'b1;
    cyc();
    mem_op("post_reset", RDL, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF);
`ifdef STAGE_MEM_STATS_EN
    chk_w("stats stall_cycles", stall_cycles, 32'd3);
    chk_w("stats mem_ops", mem_ops, 32'd1);
`endif
    stage_ex = STAGE_NOP;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
